pc_call_stack: RTL and testbench

//  Parametrised program counter: successor to the basic incrementing PC with absolute jump.

---
 rtl/pc_pkg.sv | 29 ++
 rtl/pc_ret_stack.sv | 51 +++++
 rtl/pc_call_stack.sv | 119 +++++++++++
 tb/tb_pc_call_stack.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter with call/return stack.
package pc_pkg;

   // Operation selected for the current edge, listed in priority order.
   typedef enum logic [2:0] {
      OP_CLR,
      OP_HOLD,
      OP_RET,
      OP_CALL,
      OP_JMP,
      OP_BR,
      OP_INC
   } pc_op_e;

   // Width used to carry a sign-extended branch offset before trimming to W.
   localparam int EXT_W = 32;

   // Sign-extend the low off_w bits of off to EXT_W bits.
   function automatic logic [EXT_W-1:0] sext_off(input logic [EXT_W-1:0] off,
                                                 input int off_w);
      logic [EXT_W-1:0] res;
      res = off;
      for (int i = 0; i < EXT_W; i++) begin
         if (i >= off_w) res[i] = off[off_w-1];
      end
      return res;
   endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address stack (LIFO). Only the stack pointer is reset;
// entries above the pointer are don't-care. Push into a full stack and pop
// from an empty stack are ignored here; the parent reports them as errors.
module pc_ret_stack #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         full,
   output logic         empty
);

   localparam int SP_W = $clog2(DEPTH + 1);
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SP_W-1:0] sp;
   logic [SP_W-1:0] sp_dec;
   logic [W-1:0]    mem [DEPTH];

   assign full   = (sp == SP_W'(DEPTH));
   assign empty  = (sp == '0);
   assign sp_dec = sp - SP_W'(1);
   assign top    = empty ? '0 : mem[AW'(sp_dec)];

   // Stack pointer: cleared by reset or clr, moves on accepted push/pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp <= '0;
      end else if (clr) begin
         sp <= '0;
      end else if (push && !full) begin
         sp <= sp + SP_W'(1);
      end else if (pop && !empty) begin
         sp <= sp_dec;
      end
   end

   // Entry storage: written at the current pointer on an accepted push, never reset.
   always_ff @(posedge clk) begin
      if (push && !full && !clr) begin
         mem[AW'(sp)] <= din;
      end
   end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with stall, absolute jump, signed relative branch,
// call/return through a hardware return stack and sticky stack error flags.
// One operation is chosen per edge: ID_rst > stall > ret > call > jmp > br > inc.
module pc_call_stack
   import pc_pkg::*;
#(
   parameter int           W       = 8,
   parameter int           OFF_W   = 8,
   parameter int           DEPTH   = 4,
   parameter logic [W-1:0] RST_VEC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ID_rst,
   input  logic             ID_en,
   input  logic             skok_pc,
   input  logic [W-1:0]     adres_skok_pc,
   input  logic             br_pc,
   input  logic [OFF_W-1:0] br_off,
   input  logic             call_pc,
   input  logic             ret_pc,
   output logic [W-1:0]     PC_count,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             err_ovf,
   output logic             err_unf
);

   pc_op_e           op;
   logic [W-1:0]     pc_next;
   logic [W-1:0]     pc_inc;
   logic [W-1:0]     pc_br;
   logic [EXT_W-1:0] off_ext;
   logic [W-1:0]     stk_top;
   logic             push;
   logic             pop;
   logic             clr;

   assign off_ext = sext_off(EXT_W'(br_off), OFF_W);
   assign pc_inc  = PC_count + W'(1);
   assign pc_br   = PC_count + off_ext[W-1:0];

   // Priority encoder: pick the single operation for this edge.
   always_comb begin
      op = OP_INC;
      if (ID_rst)       op = OP_CLR;
      else if (!ID_en)  op = OP_HOLD;
      else if (ret_pc)  op = OP_RET;
      else if (call_pc) op = OP_CALL;
      else if (skok_pc) op = OP_JMP;
      else if (br_pc)   op = OP_BR;
   end

   // Next PC and stack controls; a full call or empty ret falls through to PC+1.
   always_comb begin
      pc_next = pc_inc;
      push    = 1'b0;
      pop     = 1'b0;
      clr     = 1'b0;
      unique case (op)
         OP_CLR: begin
            pc_next = RST_VEC;
            clr     = 1'b1;
         end
         OP_HOLD: pc_next = PC_count;
         OP_RET: begin
            if (!stk_empty) begin
               pc_next = stk_top;
               pop     = 1'b1;
            end
         end
         OP_CALL: begin
            if (!stk_full) begin
               pc_next = adres_skok_pc;
               push    = 1'b1;
            end
         end
         OP_JMP:  pc_next = adres_skok_pc;
         OP_BR:   pc_next = pc_br;
         default: pc_next = pc_inc;
      endcase
   end

   // PC register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) PC_count <= RST_VEC;
      else      PC_count <= pc_next;
   end

   // Sticky error flags, cleared only by reset or ID_rst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else if (op == OP_CLR) begin
         err_ovf <= 1'b0;
         err_unf <= 1'b0;
      end else begin
         if (op == OP_CALL && stk_full)  err_ovf <= 1'b1;
         if (op == OP_RET  && stk_empty) err_unf <= 1'b1;
      end
   end

   pc_ret_stack #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: directed vector table, hand-written reset corner
// cases, then randomized traffic checked against a queue-based model.
module tb_pc_call_stack;

   localparam int W     = 8;
   localparam int OFF_W = 8;
   localparam int DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             ID_rst, ID_en, skok_pc, br_pc, call_pc, ret_pc;
   logic [W-1:0]     adres_skok_pc;
   logic [OFF_W-1:0] br_off;
   logic [W-1:0]     PC_count;
   logic             stk_full, stk_empty, err_ovf, err_unf;

   always #5 clk = ~clk;

   pc_call_stack #(
      .W       (W),
      .OFF_W   (OFF_W),
      .DEPTH   (DEPTH),
      .RST_VEC (8'h00)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ID_rst        (ID_rst),
      .ID_en         (ID_en),
      .skok_pc       (skok_pc),
      .adres_skok_pc (adres_skok_pc),
      .br_pc         (br_pc),
      .br_off        (br_off),
      .call_pc       (call_pc),
      .ret_pc        (ret_pc),
      .PC_count      (PC_count),
      .stk_full      (stk_full),
      .stk_empty     (stk_empty),
      .err_ovf       (err_ovf),
      .err_unf       (err_unf)
   );

   // ---------------- scoreboard / model ----------------
   int checks = 0;
   int errors = 0;

   // Model: PC as an integer, the return stack as a queue (back = top).
   int           m_pc;
   logic [W-1:0] exp_q[$];
   logic         m_ovf, m_unf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step(input logic clr, input logic en, input logic jmp,
                             input logic [W-1:0] addr, input logic br,
                             input logic [OFF_W-1:0] off, input logic call,
                             input logic ret);
      if (clr) begin
         model_reset();
      end else if (en) begin
         if (ret) begin
            if (exp_q.size() == 0) begin
               m_pc  = (m_pc + 1) % 256;
               m_unf = 1'b1;
            end else begin
               m_pc = int'(exp_q.pop_back());
            end
         end else if (call) begin
            if (exp_q.size() == DEPTH) begin
               m_pc  = (m_pc + 1) % 256;
               m_ovf = 1'b1;
            end else begin
               exp_q.push_back(W'((m_pc + 1) % 256));
               m_pc = int'(addr);
            end
         end else if (jmp) begin
            m_pc = int'(addr);
         end else if (br) begin
            m_pc = (m_pc + int'($signed(off)) + 256) % 256;
         end else begin
            m_pc = (m_pc + 1) % 256;
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".pc"},    32'(PC_count),  32'(m_pc));
      check({tag, ".full"},  32'(stk_full),  32'(exp_q.size() == DEPTH));
      check({tag, ".empty"}, 32'(stk_empty), 32'(exp_q.size() == 0));
      check({tag, ".ovf"},   32'(err_ovf),   32'(m_ovf));
      check({tag, ".unf"},   32'(err_unf),   32'(m_unf));
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; drives, lets one edge pass, samples at +1.
   task automatic apply(input logic clr, input logic en, input logic jmp,
                        input logic [W-1:0] addr, input logic br,
                        input logic [OFF_W-1:0] off, input logic call,
                        input logic ret);
      ID_rst        = clr;
      ID_en         = en;
      skok_pc       = jmp;
      adres_skok_pc = addr;
      br_pc         = br;
      br_off        = off;
      call_pc       = call;
      ret_pc        = ret;
      model_step(clr, en, jmp, addr, br, off, call, ret);
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic         clr, en, jmp;
      logic [W-1:0] addr;
      logic         br;
      logic [7:0]   off;
      logic         call, ret;
      logic [W-1:0] e_pc;
      logic         e_full, e_empty, e_ovf, e_unf;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic clr, input logic en, input logic jmp, input logic [7:0] addr,
                      input logic br, input logic [7:0] off, input logic call, input logic ret,
                      input logic [7:0] e_pc, input logic e_full, input logic e_empty,
                      input logic e_ovf, input logic e_unf);
      vec_t v;
      v = '{clr, en, jmp, addr, br, off, call, ret, e_pc, e_full, e_empty, e_ovf, e_unf};
      tbl.push_back(v);
   endtask

   initial begin
      // clr en jmp addr br off call ret | pc full empty ovf unf
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h01, 0, 1, 0, 0);  // inc
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h02, 0, 1, 0, 0);
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h03, 0, 1, 0, 0);
      add(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h03, 0, 1, 0, 0);  // stall
      add(0, 0, 1, 8'h77, 0, 8'h00, 1, 0, 8'h03, 0, 1, 0, 0);  // stall ignores requests
      add(0, 1, 1, 8'hAA, 0, 8'h00, 0, 0, 8'hAA, 0, 1, 0, 0);  // jump
      add(0, 1, 1, 8'hFF, 0, 8'h00, 0, 0, 8'hFF, 0, 1, 0, 0);
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0);  // wrap
      add(0, 1, 1, 8'h10, 0, 8'h00, 0, 0, 8'h10, 0, 1, 0, 0);
      add(0, 1, 0, 8'h00, 1, 8'hFD, 0, 0, 8'h0D, 0, 1, 0, 0);  // branch back 3
      add(0, 1, 1, 8'hF0, 0, 8'h00, 0, 0, 8'hF0, 0, 1, 0, 0);
      add(0, 1, 0, 8'h00, 1, 8'h20, 0, 0, 8'h10, 0, 1, 0, 0);  // branch forward, wrap
      add(0, 1, 1, 8'h33, 1, 8'h05, 0, 0, 8'h33, 0, 1, 0, 0);  // jump beats branch
      add(0, 1, 1, 8'h05, 0, 8'h00, 0, 0, 8'h05, 0, 1, 0, 0);
      add(0, 1, 0, 8'h40, 0, 8'h00, 1, 0, 8'h40, 0, 0, 0, 0);  // call
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h06, 0, 1, 0, 0);  // ret
      add(0, 1, 1, 8'h20, 0, 8'h00, 1, 0, 8'h20, 0, 0, 0, 0);  // nested calls
      add(0, 1, 0, 8'h30, 1, 8'h09, 1, 0, 8'h30, 0, 0, 0, 0);
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h21, 0, 0, 0, 0);
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h07, 0, 1, 0, 0);
      add(0, 1, 0, 8'h80, 0, 8'h00, 1, 0, 8'h80, 0, 0, 0, 0);  // fill the stack
      add(0, 1, 0, 8'h81, 0, 8'h00, 1, 0, 8'h81, 0, 0, 0, 0);
      add(0, 1, 0, 8'h82, 0, 8'h00, 1, 0, 8'h82, 0, 0, 0, 0);
      add(0, 1, 0, 8'h83, 0, 8'h00, 1, 0, 8'h83, 1, 0, 0, 0);
      add(0, 1, 0, 8'h90, 0, 8'h00, 1, 0, 8'h84, 1, 0, 1, 0);  // overflow
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h83, 0, 0, 1, 0);
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h82, 0, 0, 1, 0);
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h81, 0, 0, 1, 0);
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h08, 0, 1, 1, 0);
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h09, 0, 1, 1, 1);  // underflow
      add(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0);  // ID_rst while stalled
      add(0, 1, 1, 8'h55, 0, 8'h00, 0, 0, 8'h55, 0, 1, 0, 0);
      add(1, 1, 1, 8'h66, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0);  // ID_rst beats jump
      add(0, 1, 0, 8'h50, 0, 8'h00, 1, 1, 8'h01, 0, 1, 0, 1);  // call+ret on empty
      add(0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 8'h02, 0, 1, 0, 1);  // confirms no push
   end

   // ---------------- test sequence ----------------
   initial begin
      rst           = 1'b0;
      ID_rst        = 1'b0;
      ID_en         = 1'b0;
      skok_pc       = 1'b0;
      adres_skok_pc = '0;
      br_pc         = 1'b0;
      br_off        = '0;
      call_pc       = 1'b0;
      ret_pc        = 1'b0;
      model_reset();

      // Reset state, no clock edge involved yet.
      #2;
      check("rst.pc",    32'(PC_count),  32'h00);
      check("rst.full",  32'(stk_full),  32'h0);
      check("rst.empty", 32'(stk_empty), 32'h1);
      check("rst.ovf",   32'(err_ovf),   32'h0);
      check("rst.unf",   32'(err_unf),   32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst.pc", 32'(PC_count), 32'h00);

      // Directed table.
      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].clr, tbl[i].en, tbl[i].jmp, tbl[i].addr, tbl[i].br,
               tbl[i].off, tbl[i].call, tbl[i].ret);
         check($sformatf("vec%0d.pc", i),    32'(PC_count),  32'(tbl[i].e_pc));
         check($sformatf("vec%0d.full", i),  32'(stk_full),  32'(tbl[i].e_full));
         check($sformatf("vec%0d.empty", i), 32'(stk_empty), 32'(tbl[i].e_empty));
         check($sformatf("vec%0d.ovf", i),   32'(err_ovf),   32'(tbl[i].e_ovf));
         check($sformatf("vec%0d.unf", i),   32'(err_unf),   32'(tbl[i].e_unf));
      end

      // Asynchronous reset in the middle of a call sequence.
      apply(0, 1, 0, 8'hC0, 0, 8'h00, 1, 0);
      apply(0, 1, 0, 8'hD0, 0, 8'h00, 1, 0);
      check_model("pre_async");
      #3;
      rst = 1'b0;
      #1;
      model_reset();
      check("async.pc",    32'(PC_count),  32'h00);
      check("async.empty", 32'(stk_empty), 32'h1);
      check("async.full",  32'(stk_full),  32'h0);
      ID_en   = 1'b0;
      call_pc = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("async_rel.pc", 32'(PC_count), 32'h00);
      // A return right after reset must underflow: the stack really is empty.
      apply(0, 1, 0, 8'h00, 0, 8'h00, 0, 1);
      check_model("async_ret");

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         apply($urandom_range(0, 99) < 2,
               $urandom_range(0, 9) != 0,
               $urandom_range(0, 3) == 0,
               W'($urandom_range(0, 255)),
               $urandom_range(0, 2) == 0,
               OFF_W'($urandom_range(0, 255)),
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0);
         check_model($sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
